// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Moore-style multi-cycle control FSM for the MIPS datapath. |
// |               Sequences each instruction through fetch, decode, execute, |
// |               memory and writeback. Memory states wait on MemReady with  |
// |               a bounded timeout; illegal opcodes and timeouts enter a    |
// |               sticky FAULT state that only Rst leaves.                   |
// | Option      : `define JUMP_EN builds the JUMP state (opcode 000010);     |
// |               without it that opcode is treated as illegal.              |
// | Ports       : Clk, Rst (sync, active-high), Instruction[31:0] (only      |
// |               [31:26] decoded), MemReady; datapath controls PCWrite,     |
// |               PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,   |
// |               RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],       |
// |               PCSource[1:0]; debug State[3:0], Fault, FaultCode[1:0].    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15  // legal range 1..255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        Fault,
  output logic [1:0]  FaultCode
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
`ifdef JUMP_EN
    S_JUMP      = 4'd9,
`endif
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
  localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

  localparam logic [1:0] c_FC_NONE    = 2'b00;
  localparam logic [1:0] c_FC_ILLEGAL = 2'b01;
  localparam logic [1:0] c_FC_TIMEOUT = 2'b10;

  localparam logic [7:0] c_WAIT_MAX = MEM_WAIT_MAX[7:0];

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [1:0]  r_fault_code;
  logic [1:0]  w_next_fault_code;
  logic        r_is_store;   // lw/sw captured in DECODE; Instruction is not trusted later
  logic        w_mem_state;
  logic        w_next_mem;
  logic        w_timeout;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic [5:0]  w_opcode;
  logic        w_unused_instr;

  assign w_opcode       = Instruction[31:26];
  assign w_unused_instr = ^Instruction[25:0];

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  assign w_next_mem  = (w_next_state == S_FETCH) || (w_next_state == S_MEM_READ) ||
                       (w_next_state == S_MEM_WRITE);
  // Ready has priority: the timeout only fires when the access has not completed.
  assign w_timeout   = w_mem_state && !MemReady && (r_wait_cnt == c_WAIT_MAX);
  // Clear only on a real entry; staying in a waiting state must keep counting.
  assign w_cnt_clear = w_next_mem && (w_next_state != r_state);
  assign w_cnt_inc   = w_mem_state && !MemReady;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= 8'd0;
      r_fault_code <= c_FC_NONE;
      r_is_store   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_fault_code <= w_next_fault_code;
      if (r_state == S_DECODE) begin
        r_is_store <= (w_opcode == c_OP_SW);
      end
      if (w_cnt_clear) begin
        r_wait_cnt <= 8'd0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state      = r_state;
    w_next_fault_code = r_fault_code;
    case (r_state)
      S_FETCH: begin
        if (MemReady) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state      = S_FAULT;
          w_next_fault_code = c_FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          c_OP_RTYPE:      w_next_state = S_R_EXEC;
          c_OP_LW, c_OP_SW: w_next_state = S_MEM_ADDR;
          c_OP_BEQ:        w_next_state = S_BRANCH;
          c_OP_ADDI:       w_next_state = S_I_EXEC;
`ifdef JUMP_EN
          c_OP_J:          w_next_state = S_JUMP;
`endif
          default: begin
            w_next_state      = S_FAULT;
            w_next_fault_code = c_FC_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR:  w_next_state = r_is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ, S_MEM_WRITE: begin
        if (MemReady) begin
          w_next_state = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next_state      = S_FAULT;
          w_next_fault_code = c_FC_TIMEOUT;
        end
      end
      S_MEM_WB:    w_next_state = S_FETCH;
      S_R_EXEC:    w_next_state = S_R_WB;
      S_R_WB:      w_next_state = S_FETCH;
      S_BRANCH:    w_next_state = S_FETCH;
`ifdef JUMP_EN
      S_JUMP:      w_next_state = S_FETCH;
`endif
      S_I_EXEC:    w_next_state = S_I_WB;
      S_I_WB:      w_next_state = S_FETCH;
      S_FAULT:     w_next_state = S_FAULT;
      default:     w_next_state = S_FAULT;
    endcase
  end

  // Moore outputs; only FETCH looks at MemReady, to gate the IR/PC loads.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE:    ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
      end
      S_I_WB:      RegWrite = 1'b1;
      default: ;
    endcase
    // Reset overrides every write/request so an aborted instruction has no side effect.
    if (Rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
    end
  end

  assign State     = r_state;
  assign Fault     = (r_state == S_FAULT);
  assign FaultCode = r_fault_code;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style multi-cycle control FSM for the MIPS datapath, the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory states use a `MemReady` handshake with a parametrised timeout. Illegal opcodes and memory timeouts send the FSM to a sticky fault state.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum cycles a memory state waits with `MemReady`=0 before faulting; legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Instruction` in 32: instruction register contents; only `[31:26]` is decoded.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by ALU zero (beq).
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write data select; 1 = MDR.
- `RegDst` out 1: destination select; 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: 0 = PC, 1 = rs.
- `ALUSrcB` out 2: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = decode funct.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `State` out 4: current state encoding, for debug.
- `Fault` out 1: FSM is in FAULT.
- `FaultCode` out 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.

## Operation
States and encodings:
- FETCH 0
- DECODE 1
- MEM_ADDR 2
- MEM_READ 3
- MEM_WB 4
- MEM_WRITE 5
- R_EXEC 6
- R_WB 7
- BRANCH 8
- JUMP 9
- I_EXEC 10
- I_WB 11
- FAULT 15

Any output not listed for a state is 0.

State outputs and transitions:
- FETCH: `MemRead`=1, `ALUSrcB`=01. `IRWrite` and `PCWrite` are asserted only in the cycle `MemReady`=1. Goes to DECODE on `MemReady`.
- DECODE: `ALUSrcB`=11 (branch target precompute). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> I_EXEC
  - 000010 -> JUMP
  - anything else -> FAULT with `FaultCode`=01
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `MemRead`=1, `IorD`=1. Goes to MEM_WB on `MemReady`.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Goes to FETCH.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Goes to FETCH on `MemReady`.
- R_EXEC: `ALUSrcA`=1, `ALUOp`=10. Goes to R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1. Goes to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. Goes to FETCH.
- I_EXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to I_WB.
- I_WB: `RegWrite`=1, `RegDst`=0. Goes to FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Goes to FETCH.
- FAULT: every enable is 0. The state is sticky; only `Rst` leaves it.

Wait counter:
- An 8-bit counter clears on entry to each of FETCH, MEM_READ and MEM_WRITE.
- It increments each cycle those states see `MemReady`=0.
- When the counter equals `MEM_WAIT_MAX` and `MemReady`=0, the next state is FAULT with `FaultCode`=10.
- If `MemReady`=1 in that same cycle, the access completes normally; ready wins over timeout.

## Timing
- Reset: on a rising edge with `Rst`=1, state becomes FETCH, the counter clears and `FaultCode` becomes 00.
- While `Rst` is high, `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemRead` and `MemWrite` are forced to 0.
- `Rst` mid-instruction aborts the instruction; no write enable is asserted in the following cycle.
- Outputs are combinational from the state register (plus `MemReady` gating in FETCH) and valid in the same cycle as the state.
- Zero-wait latency in cycles, FETCH entry to next FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each cycle with `MemReady`=0 in a memory state adds one cycle.
- `MemReady` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- `Instruction` is sampled only in DECODE.

## Configuration
- `JUMP_EN` defined: opcode 000010 decodes to JUMP as above.
- `JUMP_EN` undefined: the JUMP state is not built, and opcode 000010 goes to FAULT with `FaultCode`=01.

## Test plan
- Rst high 2 cycles, then opcode 000000 with `MemReady` held 1 -> `State` sequence 0,1,6,7,0; `RegWrite`=1 with `RegDst`=1 only in state 7; `IRWrite`=1 only in the first cycle.
- lw (100011), `MemReady` low for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; `IorD`=1 throughout state 3; `MemtoReg`=1 in state 4.
- sw with `MemReady` low for `MEM_WAIT_MAX`+1 cycles -> FAULT, `Fault`=1, `FaultCode`=10. The FSM holds FAULT for 20 further cycles until `Rst`, then returns to state 0.
- `MemReady` rises exactly in the timeout cycle of FETCH -> DECODE, no fault.
- Opcode 111111 -> FAULT, `FaultCode`=01.
- Opcode 000010 -> with `JUMP_EN`: states 0,1,9,0, `PCSource`=10. Without `JUMP_EN`: FAULT with `FaultCode`=01.
- beq -> states 0,1,8,0 with `PCWriteCond`=1, `ALUOp`=01.
- `Rst` asserted in MEM_WRITE -> the next cycle has state 0 and `MemWrite`=0.
